// File: rtl/mon_prod_feeder.sv
// mon_prod_feeder: gathers A/B/M words from the UART word path, starts mon_prod, then streams P back out.
// Defining MPF_TIMEOUT_EN adds a WAIT watchdog: a sticky err flag plus an all-ones result on expiry.
module mon_prod_feeder #(
  parameter int N              = 32,
  parameter int BITLEN         = 64,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid_i,
  input  logic [N-1:0]      rx_bytes_i,
  output logic              start_o,
  output logic [BITLEN-1:0] a_o,
  output logic [BITLEN-1:0] b_o,
  output logic [BITLEN-1:0] m_o,
  input  logic              stop_i,
  input  logic [BITLEN-1:0] p_i,
  output logic              tx_valid_o,
  output logic [N-1:0]      tx_bytes_o,
  input  logic              tx_ready_i,
  output logic              busy_o,
  output logic              rx_drop_o,
  output logic              err_o
);

  localparam int WORDS = BITLEN / N;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  if ((BITLEN % N) != 0 || BITLEN < N || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("mon_prod_feeder: BITLEN must be a non-zero multiple of N and TIMEOUT_CYCLES >= 1");
  end

  // LOAD_A/B/M: collect operand words | START: pulse start | WAIT: await stop | SEND: stream result
  typedef enum logic [2:0] {LOAD_A, LOAD_B, LOAD_M, START, WAIT, SEND} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [BITLEN-1:0] a_q, b_q, m_q, res_q;
  logic              start_q, tx_valid_q, rx_drop_q;
  logic              last_word;

`ifdef MPF_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr_q;
  logic          err_q;
`endif

  assign last_word = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD_A;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      m_q        <= '0;
      res_q      <= '0;
      start_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      rx_drop_q  <= 1'b0;
`ifdef MPF_TIMEOUT_EN
      tmr_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      start_q   <= 1'b0;
      rx_drop_q <= rx_valid_i && (state_q inside {START, WAIT, SEND});
      case (state_q)
        LOAD_A: if (rx_valid_i) begin
          a_q[cnt_q*N +: N] <= rx_bytes_i;
          cnt_q <= last_word ? '0 : cnt_q + 1'b1;
          if (last_word) state_q <= LOAD_B;
        end
        LOAD_B: if (rx_valid_i) begin
          b_q[cnt_q*N +: N] <= rx_bytes_i;
          cnt_q <= last_word ? '0 : cnt_q + 1'b1;
          if (last_word) state_q <= LOAD_M;
        end
        LOAD_M: if (rx_valid_i) begin
          m_q[cnt_q*N +: N] <= rx_bytes_i;
          cnt_q <= last_word ? '0 : cnt_q + 1'b1;
          if (last_word) begin
            state_q <= START;
            start_q <= 1'b1;
          end
        end
        START: begin
          state_q <= WAIT;
`ifdef MPF_TIMEOUT_EN
          tmr_q   <= TW'(TIMEOUT_CYCLES - 1);
`endif
        end
        WAIT: begin
          if (stop_i) begin
            res_q      <= p_i;
            cnt_q      <= '0;
            tx_valid_q <= 1'b1;
            state_q    <= SEND;
          end
`ifdef MPF_TIMEOUT_EN
          else if (tmr_q == '0) begin
            err_q      <= 1'b1;
            res_q      <= '1;
            cnt_q      <= '0;
            tx_valid_q <= 1'b1;
            state_q    <= SEND;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
`endif
        end
        SEND: if (tx_ready_i) begin
          if (last_word) begin
            cnt_q      <= '0;
            tx_valid_q <= 1'b0;
            state_q    <= LOAD_A;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= LOAD_A;
      endcase
    end
  end

  assign start_o    = start_q;
  assign a_o        = a_q;
  assign b_o        = b_q;
  assign m_o        = m_q;
  assign tx_valid_o = tx_valid_q;
  assign tx_bytes_o = res_q[cnt_q*N +: N];
  assign busy_o     = !(state_q == LOAD_A && cnt_q == '0);
  assign rx_drop_o  = rx_drop_q;
`ifdef MPF_TIMEOUT_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
